// File: rtl/aip_net_master_if.sv
// Host memory-mapped bus between a processor and the AIP network master.
interface aip_net_master_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/aip_net_master.sv
// AIP network master: bridges a host iomem bus to the AIP config/data strobes
// and turns the AIP interrupt into a done flag plus host irq.
module aip_net_master (
  input  logic                    clk,
  input  logic                    resetn,
  aip_net_master_if.slave         bus,
  output logic [4:0]              conf_dbus,
  output logic                    read,
  output logic                    write,
  output logic                    start,
  output logic [31:0]             data_out,
  input  logic [31:0]             data_in,
  input  logic                    int_req,
  output logic                    irq
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_ACK} state_t;

  localparam logic [1:0] A_CONFIG = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_START  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_t      state_q, state_d;
  logic [4:0]  cfg_q, cfg_d;
  logic        ie_q, ie_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        int_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] dout_q, dout_d;
  logic        ready_q, read_q, write_q, start_q, irq_q;
  logic        start_d;

  logic [1:0]  sel;
  logic        is_wr;
  logic        in_ack;
  logic        int_edge;
  logic        acc_start;
  logic [31:0] reg_val;
  logic        unused_addr;

  assign sel         = bus.iomem_addr[3:2];
  assign is_wr       = |bus.iomem_wstrb;
  assign in_ack      = (state_q == S_ACK);
  assign int_edge    = int_req & ~int_q;
  assign acc_start   = in_ack & is_wr & (sel == A_START);
  assign unused_addr = ^{bus.iomem_addr[31:4], bus.iomem_addr[1:0]};

  // Transaction sequencing: register accesses go straight to ACK, DATA goes through the AIP strobes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iomem_valid) begin
          if (sel == A_DATA) state_d = is_wr ? S_WR : S_RD;
          else               state_d = S_ACK;
        end
      end
      S_WR:    state_d = S_ACK;
      S_RD:    state_d = S_RDW;
      S_RDW:   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register side effects at the end of ACK; an int_req edge wins over any clear of done
  always_comb begin
    cfg_d  = cfg_q;
    ie_d   = ie_q;
    busy_d = busy_q;
    done_d = done_q;
    if (in_ack && is_wr && sel == A_CONFIG) begin
      cfg_d = bus.iomem_wdata[4:0];
      ie_d  = bus.iomem_wdata[8];
    end
    if (acc_start) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end
    if (in_ack && is_wr && sel == A_STATUS && bus.iomem_wdata[1]) done_d = 1'b0;
    if (int_edge) begin
      done_d = 1'b1;
      if (!acc_start) busy_d = 1'b0;
    end
  end

  // Read data: register reads snapshot at acceptance, DATA reads capture the AIP bus in RDW
  always_comb begin
    unique case (sel)
      A_CONFIG: reg_val = {23'd0, ie_q, 3'd0, cfg_q};
      A_STATUS: reg_val = {30'd0, done_q, busy_q};
      default:  reg_val = 32'd0;
    endcase
    rdata_d = rdata_q;
    if (state_q == S_IDLE && bus.iomem_valid && !is_wr && sel != A_DATA) rdata_d = reg_val;
    if (state_q == S_RDW) rdata_d = data_in;
    dout_d  = (state_d == S_WR) ? bus.iomem_wdata : dout_q;
    start_d = (state_q == S_IDLE) && bus.iomem_valid && is_wr && (sel == A_START);
  end

  // All state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cfg_q   <= 5'd0;
      ie_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      int_q   <= 1'b0;
      rdata_q <= 32'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      ie_q    <= ie_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      int_q   <= int_req;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      ready_q <= (state_d == S_ACK);
      read_q  <= (state_d == S_RD);
      write_q <= (state_d == S_WR);
      start_q <= start_d;
      irq_q   <= done_d & ie_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign conf_dbus       = cfg_q;
  assign read            = read_q;
  assign write           = write_q;
  assign start           = start_q;
  assign data_out        = dout_q;
  assign irq             = irq_q;
endmodule

// File: doc/aip_net_master.md
AIP_NET_MASTER -- requirements
Module: aip_net_master

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port iomem_valid, input, 1: host request valid; window decode is done outside this block.
REQ-004 SHALL have port iomem_ready, output, 1: one-cycle transaction acknowledge.
REQ-005 SHALL have port iomem_wstrb, input, 4: nonzero means write, zero means read; partial strobes are treated as a full-word write.
REQ-006 SHALL have port iomem_addr, input, 32: only bits [3:2] are decoded.
REQ-007 SHALL have port iomem_wdata, input, 32: host write data.
REQ-008 SHALL have port iomem_rdata, output, 32: host read data, valid while iomem_ready=1.
REQ-009 SHALL have port conf_dbus, output, 5: AIP config selector.
REQ-010 SHALL have port read, output, 1: AIP read strobe.
REQ-011 SHALL have port write, output, 1: AIP write strobe.
REQ-012 SHALL have port start, output, 1: AIP start pulse.
REQ-013 SHALL have port data_out, output, 32: data driven to the AIP data_in.
REQ-014 SHALL have port data_in, input, 32: data returned from the AIP data_out.
REQ-015 SHALL have port int_req, input, 1: AIP interrupt, synchronous to clk.
REQ-016 SHALL have port irq, output, 1: host interrupt.

Function
REQ-017 Register map SHALL be: addr[3:2]=0 CONFIG (bits[4:0] cfg, bit8 ie); 1 DATA; 2 START (write-only, reads return 0); 3 STATUS (bit0 busy, bit1 done, W1C on done).
REQ-018 FSM SHALL have the states IDLE, WR, RD, RDW and ACK.
REQ-019 IDLE transitions SHALL be: on iomem_valid, DATA write -> WR, DATA read -> RD, any other access -> ACK.
REQ-020 WR SHALL last one cycle with write=1, conf_dbus=cfg and data_out=iomem_wdata, then go to ACK.
REQ-021 RD SHALL last one cycle with read=1 and conf_dbus=cfg, then go to RDW.
REQ-022 RDW SHALL capture data_in into the read-data register, then go to ACK.
REQ-023 ACK SHALL hold iomem_ready=1 for exactly one cycle with iomem_rdata valid, apply register side effects, then return to IDLE.
REQ-024 Latencies from valid sampled in IDLE to ready SHALL be: register access 1 cycle, DATA write 2 cycles, DATA read 3 cycles.
REQ-025 The host SHALL drop iomem_valid on the clock edge where ready is seen; valid is sampled again only in IDLE.
REQ-026 A START write SHALL assert start=1 during its ACK cycle, set busy=1 and clear done.
REQ-027 A rising edge of int_req (registered previous value low, current value high) SHALL set done=1 and busy=0; a level held high SHALL NOT re-set done after a clear.
REQ-028 A done set and a STATUS W1C in the same cycle SHALL resolve as set wins.
REQ-029 A START in the same cycle as an int_req edge SHALL give busy=1 and done=1.
REQ-030 A START while busy=1 SHALL still pulse start, keep busy=1 and clear done.
REQ-031 irq SHALL equal done AND ie, registered.
REQ-032 conf_dbus SHALL hold cfg at all times; data_out SHALL hold its last written value.
REQ-033 read, write and start SHALL be registered single-cycle pulses and SHALL never assert simultaneously.

Reset
REQ-034 While resetn=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and cfg, ie, busy, done, the read-data register and the int_req edge register SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no ready; the host retries.
REQ-036 Deassertion SHALL be synchronous to clk.

Verification
REQ-037 Write CONFIG=0x105, then read it -> ready after 1 cycle, rdata=0x105, conf_dbus=5'h05.
REQ-038 Write DATA=0xDEADBEEF -> write=1 for one cycle with data_out=0xDEADBEEF, ready 2 cycles after valid.
REQ-039 Read DATA with data_in=0x12345678 one cycle after read -> rdata=0x12345678, ready 3 cycles after valid.
REQ-040 Write START, then raise int_req after 10 cycles -> start one pulse, STATUS=0x1 before the edge, 0x2 after, irq=1 with ie=1.
REQ-041 Write STATUS=0x2 in the same cycle as an int_req edge -> done stays 1; a later clear with int_req held high gives done=0.
REQ-042 Assert resetn=0 during RDW -> no ready, all outputs 0, and the next transaction completes normally.
